// File: rtl/i2c_arb_pkg.sv
// rtl/i2c_arb_pkg.sv - shared types and constants for the I2C command arbiter
//
// Purpose : arbiter FSM state encoding, command direction values and the
//           field widths used by i2c_cmd_arbiter and its testbench.
// Ports   : none (package).
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  localparam logic WRITE = 1'b1;
  localparam logic READ  = 1'b0;

  localparam int DEV_W  = 7;
  localparam int BYTE_W = 8;

endpackage

// File: rtl/i2c_cmd_arbiter_rr_pick.sv
// rtl/i2c_cmd_arbiter_rr_pick.sv - combinational round-robin selector
//
// Purpose : returns the first set request bit at or after ptr, wrapping
//           around N requesters.
// Ports   : req    - request vector
//           ptr    - search start index (0..N-1)
//           onehot - one-hot of the winner, 0 if none
//           idx    - index of the winner, 0 if none
//           any    - at least one request set
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int k;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    k      = 0;
    for (int i = 0; i < N; i++) begin
      // ptr never exceeds N-1, so one subtraction is enough to wrap.
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!any && req[k]) begin
        any       = 1'b1;
        onehot[k] = 1'b1;
        idx       = IW'(k);
      end
    end
  end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// rtl/i2c_cmd_arbiter.sv - round-robin sharing of one I2C master among sequencers
//
// Purpose : grants the I2C master to one of NUM_REQ command sequencers
//           (rqt/done handshake), latches its command fields at grant and
//           returns done / read data only to the granted requester.
// Option  : define I2C_CMD_ARB_TIMEOUT_EN to enable the ACTIVE watchdog
//           (TIMEOUT_CYCLES, TO_W); otherwise req_err is tied to 0.
// Ports   : clk, rst_n                        - clock, async active-low reset
//           req_rqt/req_cmd                   - per-requester request, 1=write
//           req_addr_dev (7b each)            - device address per requester
//           req_addr_reg_H/L, req_data_wr_H/L - 8b fields per requester
//           req_done, req_data_rdy            - completion gated by grant
//           req_data_rd                       - read data, broadcast
//           req_err                           - one-cycle watchdog pulse
//           grant, busy                       - current owner, not idle
//           m_cmd, m_addr_dev, m_addr_reg_H/L, m_data_wr_H/L, m_i2c_rqt - to master
//           m_i2c_done, m_data_rdy, m_data_rd - from master
module i2c_cmd_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int TO_W           = 21
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_rqt,
  input  logic [NUM_REQ-1:0]          req_cmd,
  input  logic [DEV_W*NUM_REQ-1:0]    req_addr_dev,
  input  logic [BYTE_W*NUM_REQ-1:0]   req_addr_reg_H,
  input  logic [BYTE_W*NUM_REQ-1:0]   req_addr_reg_L,
  input  logic [BYTE_W*NUM_REQ-1:0]   req_data_wr_H,
  input  logic [BYTE_W*NUM_REQ-1:0]   req_data_wr_L,
  output logic [NUM_REQ-1:0]          req_done,
  output logic [NUM_REQ-1:0]          req_data_rdy,
  output logic [BYTE_W-1:0]           req_data_rd,
  output logic [NUM_REQ-1:0]          req_err,
  output logic [NUM_REQ-1:0]          grant,
  output logic                        busy,
  output logic                        m_cmd,
  output logic [DEV_W-1:0]            m_addr_dev,
  output logic [BYTE_W-1:0]           m_addr_reg_H,
  output logic [BYTE_W-1:0]           m_addr_reg_L,
  output logic [BYTE_W-1:0]           m_data_wr_H,
  output logic [BYTE_W-1:0]           m_data_wr_L,
  output logic                        m_i2c_rqt,
  input  logic                        m_i2c_done,
  input  logic                        m_data_rdy,
  input  logic [BYTE_W-1:0]           m_data_rd
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Elaboration-time parameter guards.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("i2c_cmd_arbiter: NUM_REQ must be 2..8");
  end
  if (TO_W < 1 || TIMEOUT_CYCLES < 1 ||
      (64'd1 << TO_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_to_w
    $error("i2c_cmd_arbiter: TO_W too narrow for TIMEOUT_CYCLES");
  end

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               rqt_q, rqt_d;
  logic               load;
  logic               done_s1;
  logic               fall;
  logic               timeout;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_rr_pick (
    .req    (req_rqt),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // done_s1 runs in every state so a done already high when ACTIVE is
  // entered still yields a fall in the first ACTIVE cycle.
  assign fall = done_s1 & ~m_i2c_done;

`ifdef I2C_CMD_ARB_TIMEOUT_EN
  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0]    wd_q;
  logic [NUM_REQ-1:0] err_q;

  // wd_q holds the number of completed ACTIVE cycles; a fall in the expiry
  // cycle wins, so it completes normally without err.
  assign timeout = (state_q == ST_ACTIVE) && !fall && (wd_q == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q  <= '0;
      err_q <= '0;
    end else begin
      err_q <= timeout ? grant_q : '0;
      if (load) begin
        wd_q <= '0;
      end else if (state_q == ST_ACTIVE) begin
        wd_q <= wd_q + 1'b1;
      end
    end
  end

  assign req_err = err_q;
`else
  assign timeout = 1'b0;
  assign req_err = '0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    rqt_d   = rqt_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_onehot;
          gidx_d  = pick_idx;
          rqt_d   = 1'b1;
          load    = 1'b1;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (fall || timeout) begin
          rqt_d   = 1'b0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // Grant is held through this cycle so the owner's done-fall
        // detection still sees itself selected; the pointer moves past the
        // owner so an immediate re-request loses to anyone else pending.
        grant_d = '0;
        ptr_d   = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        rqt_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      rqt_q   <= 1'b0;
      done_s1 <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      rqt_q   <= rqt_d;
      done_s1 <= m_i2c_done;
    end
  end

  // Command fields are captured once at grant and frozen until next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cmd        <= READ;
      m_addr_dev   <= '0;
      m_addr_reg_H <= '0;
      m_addr_reg_L <= '0;
      m_data_wr_H  <= '0;
      m_data_wr_L  <= '0;
    end else if (load) begin
      m_cmd        <= req_cmd[pick_idx];
      m_addr_dev   <= req_addr_dev[pick_idx*DEV_W +: DEV_W];
      m_addr_reg_H <= req_addr_reg_H[pick_idx*BYTE_W +: BYTE_W];
      m_addr_reg_L <= req_addr_reg_L[pick_idx*BYTE_W +: BYTE_W];
      m_data_wr_H  <= req_data_wr_H[pick_idx*BYTE_W +: BYTE_W];
      m_data_wr_L  <= req_data_wr_L[pick_idx*BYTE_W +: BYTE_W];
    end
  end

  assign grant        = grant_q;
  assign busy         = (state_q != ST_IDLE);
  assign m_i2c_rqt    = rqt_q;
  assign req_done     = {NUM_REQ{m_i2c_done}} & grant_q;
  assign req_data_rdy = {NUM_REQ{m_data_rdy}} & grant_q;
  assign req_data_rd  = m_data_rd;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb/tb_i2c_cmd_arbiter.sv - self-checking bench for i2c_cmd_arbiter
//
// Purpose : directed and randomized transactions; the bench plays both the
//           requesters and the I2C master and predicts grants with a
//           round-robin pointer model. Define I2C_CMD_ARB_TIMEOUT_EN to also
//           exercise the watchdog (TIMEOUT_CYCLES=100).
// Ports   : none (top-level bench).
module tb_i2c_cmd_arbiter;
  import i2c_arb_pkg::*;

  localparam int N  = 3;
  localparam int TO = 100;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_rqt, req_cmd;
  logic [7*N-1:0] req_addr_dev;
  logic [8*N-1:0] req_addr_reg_H, req_addr_reg_L, req_data_wr_H, req_data_wr_L;
  logic [N-1:0]   req_done, req_data_rdy, req_err, grant;
  logic [7:0]     req_data_rd;
  logic           busy, m_cmd, m_i2c_rqt, m_i2c_done, m_data_rdy;
  logic [6:0]     m_addr_dev;
  logic [7:0]     m_addr_reg_H, m_addr_reg_L, m_data_wr_H, m_data_wr_L, m_data_rd;

  int n_cmp = 0;
  int n_bad = 0;
  int ptr_m = 0;

  i2c_cmd_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO),
    .TO_W           (21)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_rqt        (req_rqt),
    .req_cmd        (req_cmd),
    .req_addr_dev   (req_addr_dev),
    .req_addr_reg_H (req_addr_reg_H),
    .req_addr_reg_L (req_addr_reg_L),
    .req_data_wr_H  (req_data_wr_H),
    .req_data_wr_L  (req_data_wr_L),
    .req_done       (req_done),
    .req_data_rdy   (req_data_rdy),
    .req_data_rd    (req_data_rd),
    .req_err        (req_err),
    .grant          (grant),
    .busy           (busy),
    .m_cmd          (m_cmd),
    .m_addr_dev     (m_addr_dev),
    .m_addr_reg_H   (m_addr_reg_H),
    .m_addr_reg_L   (m_addr_reg_L),
    .m_data_wr_H    (m_data_wr_H),
    .m_data_wr_L    (m_data_wr_L),
    .m_i2c_rqt      (m_i2c_rqt),
    .m_i2c_done     (m_i2c_done),
    .m_data_rdy     (m_data_rdy),
    .m_data_rd      (m_data_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first pending requester at or after the pointer.
  function automatic int model_pick(input logic [N-1:0] pend, input int p);
    for (int i = 0; i < N; i++) begin
      if (pend[(p + i) % N]) return (p + i) % N;
    end
    return 0;
  endfunction

  task automatic rand_fields();
    req_cmd        = N'($urandom);
    req_addr_dev   = (7*N)'({$urandom, $urandom});
    req_addr_reg_H = (8*N)'($urandom);
    req_addr_reg_L = (8*N)'($urandom);
    req_data_wr_H  = (8*N)'($urandom);
    req_data_wr_L  = (8*N)'($urandom);
  endtask

  // Called one cycle after the requests were presented.
  task automatic expect_grant(input int k);
    chk("grant",     32'(grant), 32'(1 << k));
    chk("m_i2c_rqt", 32'(m_i2c_rqt), 32'(1));
    chk("busy",      32'(busy), 32'(1));
    chk("m_cmd",     32'(m_cmd), 32'(req_cmd[k]));
    chk("m_dev",     32'(m_addr_dev),   32'(req_addr_dev[k*7 +: 7]));
    chk("m_reg_H",   32'(m_addr_reg_H), 32'(req_addr_reg_H[k*8 +: 8]));
    chk("m_reg_L",   32'(m_addr_reg_L), 32'(req_addr_reg_L[k*8 +: 8]));
    chk("m_wr_H",    32'(m_data_wr_H),  32'(req_data_wr_H[k*8 +: 8]));
    chk("m_wr_L",    32'(m_data_wr_L),  32'(req_data_wr_L[k*8 +: 8]));
  endtask

  // Master side: wait pre cycles, hold done for dlen cycles, then follow
  // the fall through RELEASE back to IDLE.
  task automatic serve(input int k, input int pre, input int dlen,
                       input bit rd, input logic [7:0] rdat);
    repeat (pre) begin
      tick();
      chk("rqt_hold", 32'(m_i2c_rqt), 32'(1));
    end
    m_i2c_done = 1'b1;
    m_data_rdy = rd;
    m_data_rd  = rdat;
    for (int c = 0; c < dlen; c++) begin
      #1;
      chk("req_done", 32'(req_done), 32'(1 << k));
      if (rd && c == 0) begin
        chk("req_data_rdy", 32'(req_data_rdy), 32'(1 << k));
        chk("req_data_rd",  32'(req_data_rd), 32'(rdat));
      end
      tick();
      chk("rqt_during_done", 32'(m_i2c_rqt), 32'(1));
      m_data_rdy = 1'b0;
    end
    m_i2c_done = 1'b0;
    tick();
    chk("rel_rqt",   32'(m_i2c_rqt), 32'(0));
    chk("rel_grant", 32'(grant), 32'(1 << k));
    chk("rel_busy",  32'(busy), 32'(1));
    chk("no_err",    32'(req_err), 32'(0));
    tick();
    chk("idle_grant", 32'(grant), 32'(0));
    chk("idle_busy",  32'(busy), 32'(0));
    chk("idle_rqt",   32'(m_i2c_rqt), 32'(0));
    ptr_m = (k + 1) % N;
  endtask

  initial begin
    int seq [4] = '{0, 1, 2, 0};
    int k, k2;
    logic [N-1:0] mask;

    rst_n = 1'b0;
    req_rqt = '0; req_cmd = '0; req_addr_dev = '0;
    req_addr_reg_H = '0; req_addr_reg_L = '0; req_data_wr_H = '0; req_data_wr_L = '0;
    m_i2c_done = 1'b0; m_data_rdy = 1'b0; m_data_rd = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset state.
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_busy",  32'(busy), 32'(0));
    chk("rst_rqt",   32'(m_i2c_rqt), 32'(0));
    chk("rst_dev",   32'(m_addr_dev), 32'(0));
    chk("rst_wr_H",  32'(m_data_wr_H), 32'(0));
    chk("rst_err",   32'(req_err), 32'(0));

    // Single write from requester 2.
    req_addr_dev[14 +: 7]  = 7'h3B;
    req_addr_reg_H[16 +: 8] = 8'hC7;
    req_data_wr_H[16 +: 8]  = 8'h00;
    req_cmd[2] = WRITE;
    req_rqt = 3'b100;
    tick();
    expect_grant(2);
    chk("w_dev", 32'(m_addr_dev), 32'h3B);
    chk("w_regH", 32'(m_addr_reg_H), 32'hC7);
    serve(2, 1, 4, 1'b0, 8'h00);
    req_rqt = '0;

    // Contention, all three held continuously.
    rand_fields();
    req_rqt = 3'b111;
    for (int i = 0; i < 4; i++) begin
      tick();
      k = model_pick(req_rqt, ptr_m);
      chk("rr_order", 32'(k), 32'(seq[i]));
      expect_grant(k);
      serve(k, 0, 2, 1'b0, 8'h00);
    end
    req_rqt = '0;

    // Field freeze: requester 1 changes its data while ACTIVE.
    req_data_wr_H[8 +: 8] = 8'h02;
    req_rqt = 3'b010;
    tick();
    expect_grant(1);
    req_data_wr_H[8 +: 8] = 8'h3A;
    req_rqt = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("freeze_wr_H", 32'(m_data_wr_H), 32'h02);
      chk("freeze_rqt",  32'(m_i2c_rqt), 32'(1));
    end
    serve(1, 0, 2, 1'b0, 8'h00);

    // Read return to requester 0 (pointer wraps from 2).
    req_cmd[0] = READ;
    req_rqt = 3'b001;
    tick();
    expect_grant(0);
    serve(0, 1, 2, 1'b1, 8'h5A);
    req_rqt = '0;

    // Reset mid-ACTIVE; pointer returns to 0.
    req_rqt = 3'b100;
    tick();
    expect_grant(2);
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_grant", 32'(grant), 32'(0));
    chk("arst_rqt",   32'(m_i2c_rqt), 32'(0));
    chk("arst_busy",  32'(busy), 32'(0));
    tick();
    rst_n = 1'b1;
    ptr_m = 0;
    req_rqt = 3'b101;
    tick();
    k = model_pick(req_rqt, ptr_m);
    chk("post_rst_pick", 32'(k), 32'(0));
    expect_grant(k);
    req_rqt = '0;
    serve(k, 0, 1, 1'b0, 8'h00);

    // Master done already high when ACTIVE is entered.
    m_i2c_done = 1'b1;
    req_rqt = 3'b100;
    #1;
    chk("done_idle_gated", 32'(req_done), 32'(0));
    tick();
    expect_grant(2);
    chk("done_entry_fwd", 32'(req_done), 32'(3'b100));
    req_rqt = '0;
    m_i2c_done = 1'b0;
    tick();
    chk("entry_fall_rqt", 32'(m_i2c_rqt), 32'(0));
    chk("entry_fall_grant", 32'(grant), 32'(3'b100));
    tick();
    chk("entry_idle", 32'(grant), 32'(0));
    ptr_m = 0;

    // Randomized transactions.
    for (int t = 0; t < 24; t++) begin
      rand_fields();
      mask = N'($urandom_range(1, 7));
      req_rqt = mask;
      tick();
      k = model_pick(mask, ptr_m);
      expect_grant(k);
      if ($urandom_range(0, 1) == 1) req_rqt[k] = 1'b0;
      serve(k, $urandom_range(0, 3), $urandom_range(1, 4), !req_cmd[k], 8'($urandom));
    end
    req_rqt = '0;

`ifdef I2C_CMD_ARB_TIMEOUT_EN
    // Watchdog: master never responds.
    rand_fields();
    mask = 3'b011;
    req_rqt = mask;
    tick();
    k = model_pick(mask, ptr_m);
    expect_grant(k);
    repeat (TO - 1) tick();
    chk("wd_pre_rqt", 32'(m_i2c_rqt), 32'(1));
    chk("wd_pre_err", 32'(req_err), 32'(0));
    tick();
    chk("wd_rqt",   32'(m_i2c_rqt), 32'(0));
    chk("wd_err",   32'(req_err), 32'(1 << k));
    chk("wd_grant", 32'(grant), 32'(1 << k));
    mask[k] = 1'b0;
    req_rqt = mask;
    ptr_m = (k + 1) % N;
    tick();
    chk("wd_err_clr", 32'(req_err), 32'(0));
    chk("wd_idle",    32'(grant), 32'(0));
    tick();
    k2 = model_pick(mask, ptr_m);
    expect_grant(k2);
    req_rqt = '0;
    serve(k2, 0, 1, 1'b0, 8'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
